// File: rtl/fetch_mem_sequencer.sv
// Fetch/data sequencer for a single-port shared instruction/data memory.
// It owns the PC, time-multiplexes the port via sclk and serves one data request at a time.
module fetch_mem_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64,
  parameter logic [31:0] NOP_INST   = 32'h0000_0033
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_pc_o,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_i,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [1:0]  dm_size_i,
  input  logic        dm_signed_i,
  input  logic [7:0]  dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic        dm_ack_o,
  output logic [31:0] dm_rdata_o,
  output logic        sclk_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [1:0]  mem_sel_o,
  output logic        mem_signed_o,
  output logic [7:0]  mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        fetch_err_o
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DSETUP  = 2'd1,
    DACCESS = 2'd2,
    HALTED  = 2'd3
  } state_t;

  localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] if_inst_q;
  logic [31:0] if_pc_q;
  logic        if_valid_q;
  logic        dm_ack_q;
  logic [31:0] dm_rdata_q;
  logic        sclk_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [1:0]  mem_sel_q;
  logic        mem_signed_q;
  logic [7:0]  mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        fetch_err_q;
  logic        halt_pend_q;

  logic dm_start;
  logic fetch_go;
  logic redir_go;
  logic out_of_range;

  // The ack cycle still sees the old request held high; it must not start a second access.
  assign dm_start     = (state_q == FETCH) && dm_req_i && !dm_ack_q;
  assign redir_go     = redirect_i && (state_q != HALTED);
  assign fetch_go     = (state_q == FETCH) && !dm_start && !halt_i && !redirect_i &&
                        (!if_valid_q || if_ready_i);
  assign out_of_range = (pc_q[31:2] >= IMEM_LIMIT);

  always_comb begin
    pc_d = pc_q;
    if (redir_go) begin
      pc_d = {redirect_pc_i[31:2], 2'b00};
    end else if (fetch_go) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      if_inst_q    <= NOP_INST;
      if_pc_q      <= 32'h0;
      if_valid_q   <= 1'b0;
      dm_ack_q     <= 1'b0;
      dm_rdata_q   <= 32'h0;
      sclk_q       <= 1'b1;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_sel_q    <= 2'b00;
      mem_signed_q <= 1'b0;
      mem_addr_q   <= 8'h0;
      mem_wdata_q  <= 32'h0;
      fetch_err_q  <= 1'b0;
      halt_pend_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      dm_ack_q <= 1'b0;

      if (redir_go && (redirect_pc_i[1:0] != 2'b00)) begin
        fetch_err_q <= 1'b1;
      end

      // Decode handshake: flush on redirect, refill on fetch, otherwise drop once consumed.
      if (redir_go) begin
        if_valid_q <= 1'b0;
      end else if (fetch_go) begin
        if_valid_q <= 1'b1;
        if_pc_q    <= pc_q;
        if (out_of_range) begin
          if_inst_q   <= NOP_INST;
          fetch_err_q <= 1'b1;
        end else begin
          if_inst_q <= mem_rdata_i;
        end
      end else if (if_ready_i) begin
        if_valid_q <= 1'b0;
      end

      case (state_q)
        FETCH: begin
          if (dm_start) begin
            state_q      <= DSETUP;
            mem_addr_q   <= dm_addr_i;
            mem_wdata_q  <= dm_wdata_i;
            mem_sel_q    <= dm_size_i;
            mem_signed_q <= dm_signed_i;
            mem_write_q  <= dm_we_i;
            mem_read_q   <= ~dm_we_i;
            halt_pend_q  <= halt_i;
          end else if (halt_i) begin
            state_q <= HALTED;
          end else begin
            // Address always tracks the PC the next fetch will use.
            mem_addr_q <= {2'b00, pc_d[7:2]};
          end
        end
        DSETUP: begin
          state_q <= DACCESS;
          sclk_q  <= 1'b0;
          if (halt_i) begin
            halt_pend_q <= 1'b1;
          end
        end
        DACCESS: begin
          dm_ack_q    <= 1'b1;
          sclk_q      <= 1'b1;
          mem_write_q <= 1'b0;
          mem_read_q  <= 1'b0;
          mem_addr_q  <= {2'b00, pc_d[7:2]};
          halt_pend_q <= 1'b0;
          if (!mem_write_q) begin
            dm_rdata_q <= mem_rdata_i;
          end
          state_q <= (halt_pend_q || halt_i) ? HALTED : FETCH;
        end
        default: begin
          state_q <= HALTED;
        end
      endcase
    end
  end

  assign if_inst_o    = if_inst_q;
  assign if_pc_o      = if_pc_q;
  assign if_valid_o   = if_valid_q;
  assign dm_ack_o     = dm_ack_q;
  assign dm_rdata_o   = dm_rdata_q;
  assign sclk_o       = sclk_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign mem_sel_o    = mem_sel_q;
  assign mem_signed_o = mem_signed_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign fetch_err_o  = fetch_err_q;

endmodule

// File: tb/tb_fetch_mem_sequencer.sv
// Bench for fetch_mem_sequencer: per-cycle vector table for fetch/data/stall traffic,
// plus hand sequences for redirect, halt, out-of-range fetch and reset during an access.
module tb_fetch_mem_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] if_inst, if_pc;
  logic        if_valid, if_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        dm_req, dm_we, dm_signed;
  logic [1:0]  dm_size;
  logic [7:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        sclk, mem_read, mem_write, mem_signed;
  logic [1:0]  mem_sel;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_mem_sequencer dut (
    .clk(clk), .rst(rst),
    .if_inst_o(if_inst), .if_pc_o(if_pc), .if_valid_o(if_valid), .if_ready_i(if_ready),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .halt_i(halt),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_size_i(dm_size), .dm_signed_i(dm_signed),
    .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata), .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata),
    .sclk_o(sclk), .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_sel_o(mem_sel),
    .mem_signed_o(mem_signed), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .fetch_err_o(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: unwritten word n reads as 32'h1000_0000+n; stores commit on sclk falling edge.
  logic [31:0] mem [256];
  bit          wr_flag [256];
  always @(negedge sclk) begin
    if (mem_write) begin
      mem[mem_addr]     <= mem_wdata;
      wr_flag[mem_addr] <= 1'b1;
    end
  end
  always_comb begin
    mem_rdata = wr_flag[mem_addr] ? mem[mem_addr] : (32'h1000_0000 + {24'h0, mem_addr});
  end

  function automatic logic [31:0] inst_at(input logic [31:0] pc);
    return 32'h1000_0000 + {2'b00, pc[31:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'b00; dm_signed = 1'b0;
    dm_addr = 8'h0; dm_wdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rdy, req, we, sg;
    logic [1:0]  size;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_ack, e_sclk, e_mw, e_mr;
    logic [31:0] e_rdata;
    logic [1:0]  e_sel;
    logic        e_sg;
  } vec_t;

  vec_t vecs [15];

  task automatic set_vec(input int i, input logic rdy, input logic req, input logic we,
                         input logic [7:0] addr, input logic [31:0] wdata, input logic [1:0] size,
                         input logic sg, input logic e_valid, input logic [31:0] e_pc,
                         input logic e_ack, input logic e_sclk, input logic e_mw, input logic e_mr,
                         input logic [31:0] e_rdata, input logic [1:0] e_sel, input logic e_sg);
    vecs[i].rdy = rdy; vecs[i].req = req; vecs[i].we = we; vecs[i].addr = addr;
    vecs[i].wdata = wdata; vecs[i].size = size; vecs[i].sg = sg;
    vecs[i].e_valid = e_valid; vecs[i].e_pc = e_pc; vecs[i].e_ack = e_ack;
    vecs[i].e_sclk = e_sclk; vecs[i].e_mw = e_mw; vecs[i].e_mr = e_mr;
    vecs[i].e_rdata = e_rdata; vecs[i].e_sel = e_sel; vecs[i].e_sg = e_sg;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // rdy req we addr wdata size sg | valid pc ack sclk mw mr rdata sel sg
    set_vec(0,  1, 0, 0, 8'h00, 32'h0,        2'b00, 0, 1, 32'h00, 0, 1, 0, 0, 32'h0,        2'b00, 0);
    set_vec(1,  1, 0, 0, 8'h00, 32'h0,        2'b00, 0, 1, 32'h04, 0, 1, 0, 0, 32'h0,        2'b00, 0);
    set_vec(2,  1, 0, 0, 8'h00, 32'h0,        2'b00, 0, 1, 32'h08, 0, 1, 0, 0, 32'h0,        2'b00, 0);
    set_vec(3,  1, 1, 1, 8'h10, 32'hDEADBEEF, 2'b00, 0, 0, 32'h08, 0, 1, 1, 0, 32'h0,        2'b00, 0);
    set_vec(4,  1, 1, 1, 8'h10, 32'hDEADBEEF, 2'b00, 0, 0, 32'h08, 0, 0, 1, 0, 32'h0,        2'b00, 0);
    set_vec(5,  1, 1, 1, 8'h10, 32'hDEADBEEF, 2'b00, 0, 0, 32'h08, 1, 1, 0, 0, 32'h0,        2'b00, 0);
    set_vec(6,  1, 1, 1, 8'h10, 32'hDEADBEEF, 2'b00, 0, 1, 32'h0C, 0, 1, 0, 0, 32'h0,        2'b00, 0);
    set_vec(7,  1, 1, 0, 8'h10, 32'h0,        2'b01, 1, 0, 32'h0C, 0, 1, 0, 1, 32'h0,        2'b01, 1);
    set_vec(8,  1, 1, 0, 8'h10, 32'h0,        2'b01, 1, 0, 32'h0C, 0, 0, 0, 1, 32'h0,        2'b01, 1);
    set_vec(9,  1, 1, 0, 8'h10, 32'h0,        2'b01, 1, 0, 32'h0C, 1, 1, 0, 0, 32'hDEADBEEF, 2'b01, 1);
    set_vec(10, 1, 1, 0, 8'h10, 32'h0,        2'b01, 1, 1, 32'h10, 0, 1, 0, 0, 32'hDEADBEEF, 2'b01, 1);
    set_vec(11, 0, 0, 0, 8'h00, 32'h0,        2'b00, 0, 1, 32'h10, 0, 1, 0, 0, 32'hDEADBEEF, 2'b01, 1);
    set_vec(12, 0, 0, 0, 8'h00, 32'h0,        2'b00, 0, 1, 32'h10, 0, 1, 0, 0, 32'hDEADBEEF, 2'b01, 1);
    set_vec(13, 0, 0, 0, 8'h00, 32'h0,        2'b00, 0, 1, 32'h10, 0, 1, 0, 0, 32'hDEADBEEF, 2'b01, 1);
    set_vec(14, 1, 0, 0, 8'h00, 32'h0,        2'b00, 0, 1, 32'h14, 0, 1, 0, 0, 32'hDEADBEEF, 2'b01, 1);

    do_reset();
    check("rst_if_valid",  {31'h0, if_valid},  32'h0);
    check("rst_if_inst",   if_inst,            32'h0000_0033);
    check("rst_if_pc",     if_pc,              32'h0);
    check("rst_sclk",      {31'h0, sclk},      32'h1);
    check("rst_mem_addr",  {24'h0, mem_addr},  32'h0);
    check("rst_mem_write", {31'h0, mem_write}, 32'h0);
    check("rst_dm_rdata",  dm_rdata,           32'h0);
    check("rst_fetch_err", {31'h0, fetch_err}, 32'h0);

    // Fetch streaming, store+load round trip, decode back-pressure
    for (int i = 0; i < 15; i++) begin
      if_ready = vecs[i].rdy; dm_req = vecs[i].req; dm_we = vecs[i].we;
      dm_addr = vecs[i].addr; dm_wdata = vecs[i].wdata; dm_size = vecs[i].size;
      dm_signed = vecs[i].sg;
      step();
      check($sformatf("v%0d_valid", i), {31'h0, if_valid}, {31'h0, vecs[i].e_valid});
      check($sformatf("v%0d_pc", i), if_pc, vecs[i].e_pc);
      check($sformatf("v%0d_inst", i), if_inst, inst_at(vecs[i].e_pc));
      check($sformatf("v%0d_ack", i), {31'h0, dm_ack}, {31'h0, vecs[i].e_ack});
      check($sformatf("v%0d_sclk", i), {31'h0, sclk}, {31'h0, vecs[i].e_sclk});
      check($sformatf("v%0d_mwrite", i), {31'h0, mem_write}, {31'h0, vecs[i].e_mw});
      check($sformatf("v%0d_mread", i), {31'h0, mem_read}, {31'h0, vecs[i].e_mr});
      check($sformatf("v%0d_rdata", i), dm_rdata, vecs[i].e_rdata);
      check($sformatf("v%0d_sel", i), {30'h0, mem_sel}, {30'h0, vecs[i].e_sel});
      check($sformatf("v%0d_signed", i), {31'h0, mem_signed}, {31'h0, vecs[i].e_sg});
      $display("vec %0d: valid=%0b pc=%h ack=%0b sclk=%0b rdata=%h", i, if_valid, if_pc, dm_ack, sclk, dm_rdata);
    end
    idle_inputs();

    // Redirect flushes the in-flight instruction; next fetch comes from the target
    redirect = 1'b1; redirect_pc = 32'h20;
    step();
    check("redir_flush_valid", {31'h0, if_valid}, 32'h0);
    redirect = 1'b0;
    step();
    check("redir_valid", {31'h0, if_valid}, 32'h1);
    check("redir_pc", if_pc, 32'h20);
    check("redir_inst", if_inst, inst_at(32'h20));
    check("redir_err_clear", {31'h0, fetch_err}, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h22;
    step();
    check("misalign_err", {31'h0, fetch_err}, 32'h1);
    redirect = 1'b0;
    step();
    check("misalign_pc", if_pc, 32'h20);
    $display("redirect: pc=%h err=%0b", if_pc, fetch_err);

    // Out-of-range fetch substitutes NOP and keeps advancing
    do_reset();
    check("oor_err_pre", {31'h0, fetch_err}, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    step();
    check("oor_pc", if_pc, 32'h100);
    check("oor_inst", if_inst, 32'h0000_0033);
    check("oor_err", {31'h0, fetch_err}, 32'h1);
    step();
    check("oor_pc_next", if_pc, 32'h104);
    check("oor_inst_next", if_inst, 32'h0000_0033);
    $display("out-of-range: pc=%h inst=%h err=%0b", if_pc, if_inst, fetch_err);

    // Asynchronous reset in the middle of a store access
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h20; dm_wdata = 32'h1234_5678;
    step();
    step();
    check("mid_sclk_low", {31'h0, sclk}, 32'h0);
    check("mid_addr", {24'h0, mem_addr}, 32'h20);
    #3;
    rst = 1'b1;
    idle_inputs();
    #1;
    check("async_rst_sclk", {31'h0, sclk}, 32'h1);
    check("async_rst_mwrite", {31'h0, mem_write}, 32'h0);
    check("async_rst_addr", {24'h0, mem_addr}, 32'h0);
    check("async_rst_wdata", mem_wdata, 32'h0);
    check("async_rst_valid", {31'h0, if_valid}, 32'h0);
    check("async_rst_inst", if_inst, 32'h0000_0033);
    check("async_rst_err", {31'h0, fetch_err}, 32'h0);
    $display("reset mid-access: sclk=%0b mem_write=%0b addr=%h", sclk, mem_write, mem_addr);
    do_reset();

    // Halt during the access phase of a store: store lands, ack pulses, then stays halted
    step();
    check("halt_pre_pc", if_pc, 32'h0);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h30; dm_wdata = 32'hCAFE_F00D;
    step();
    step();
    halt = 1'b1;
    step();
    check("halt_ack", {31'h0, dm_ack}, 32'h1);
    check("halt_mwrite", {31'h0, mem_write}, 32'h0);
    check("halt_store", wr_flag[8'h30] ? mem[8'h30] : 32'h0, 32'hCAFE_F00D);
    halt = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("halted%0d_valid", k), {31'h0, if_valid}, 32'h0);
      check($sformatf("halted%0d_mwrite", k), {31'h0, mem_write}, 32'h0);
      check($sformatf("halted%0d_sclk", k), {31'h0, sclk}, 32'h1);
      check($sformatf("halted%0d_ack", k), {31'h0, dm_ack}, 32'h0);
      check($sformatf("halted%0d_pc", k), if_pc, 32'h0);
      $display("halted %0d: valid=%0b mem_write=%0b sclk=%0b", k, if_valid, mem_write, sclk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
